// File: rtl/ttl_counter_pkg.sv
// ttl_counter_pkg: shared direction constants, width limits and all-ones TOP helper for the TTL counters
package ttl_counter_pkg;
  localparam int CNT_MIN_WIDTH = 2;
  localparam int CNT_MAX_WIDTH = 32;
  localparam logic CNT_DOWN = 1'b0;
  localparam logic CNT_UP = 1'b1;
  function automatic logic [CNT_MAX_WIDTH-1:0] cnt_all_ones(input int w);
    logic [CNT_MAX_WIDTH-1:0] r;
    r = '1;
    return r >> (CNT_MAX_WIDTH - w);
  endfunction
endpackage

// File: rtl/ttl_tc_detect.sv
// ttl_tc_detect: terminal-condition compare shared by next-state and TC_n so both always agree
module ttl_tc_detect
  import ttl_counter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] q,
  input  logic                  u_d,
  input  logic [DATA_WIDTH-1:0] top,
  output logic                  at_term
);
  assign at_term = (u_d == CNT_UP) ? (q >= top) : (q == '0);
endmodule

// File: rtl/ttl_updown_counter.sv
// ttl_updown_counter: cascadable up/down counter with async MR, gated TC_n and registered WRAP
// Define TTL_CNT_MODULO_EN to add the M port and count modulo M+1.
module ttl_updown_counter
  import ttl_counter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  MR,
  input  logic                  PE_n,
  input  logic                  U_D,
  input  logic                  CEP_n,
  input  logic                  CET_n,
  input  logic [DATA_WIDTH-1:0] P,
`ifdef TTL_CNT_MODULO_EN
  input  logic [DATA_WIDTH-1:0] M,
`endif
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  TC_n,
  output logic                  WRAP
);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = DATA_WIDTH'(cnt_all_ones(DATA_WIDTH));
  if (DATA_WIDTH < CNT_MIN_WIDTH || DATA_WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
    $error("ttl_updown_counter: DATA_WIDTH out of range");
  end
  logic [DATA_WIDTH-1:0] top, q_nxt;
  logic at_term, cnt_en;
`ifdef TTL_CNT_MODULO_EN
  assign top = M;
`else
  assign top = ALL_ONES;
`endif
  ttl_tc_detect #(.DATA_WIDTH(DATA_WIDTH)) u_tc (
    .q(Q), .u_d(U_D), .top(top), .at_term(at_term)
  );
  assign cnt_en = !CEP_n && !CET_n;
  assign q_nxt = (U_D == CNT_UP) ? (at_term ? '0 : Q + 1'b1) : (at_term ? top : Q - 1'b1);
  assign TC_n = !(!CET_n && at_term);
  always_ff @(posedge clk or posedge MR) begin
    if (MR) begin
      Q <= '0;
      WRAP <= 1'b0;
    end else if (!PE_n) begin
      Q <= P;
      WRAP <= 1'b0;
    end else begin
      Q <= cnt_en ? q_nxt : Q;
      WRAP <= cnt_en && at_term;
    end
  end
endmodule

// File: tb/tb_ttl_updown_counter.sv
// tb_ttl_updown_counter: directed and random checks of the counter and a two-stage 4-bit cascade
module tb_ttl_updown_counter;
  logic clk = 1'b0;
  logic mr = 1'b1, pe_n = 1'b1, u_d = 1'b1, cep_n = 1'b1, cet_n = 1'b1;
  logic [7:0] p = '0, m = 8'd9, q;
  logic tc_n, wrap;
  logic c_pe_n = 1'b1, c_u_d = 1'b1, c_cep_n = 1'b1, c_cet_n = 1'b1;
  logic [7:0] c_p = '0;
  logic [3:0] lo_q, hi_q;
  logic lo_tc_n, hi_tc_n, lo_wrap, hi_wrap;
  int mq = 0, cm = 0;
  bit mw = 0;
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;
  ttl_updown_counter #(.DATA_WIDTH(8)) dut (
    .clk(clk), .MR(mr), .PE_n(pe_n), .U_D(u_d), .CEP_n(cep_n), .CET_n(cet_n), .P(p),
`ifdef TTL_CNT_MODULO_EN
    .M(m),
`endif
    .Q(q), .TC_n(tc_n), .WRAP(wrap)
  );
  ttl_updown_counter #(.DATA_WIDTH(4)) u_lo (
    .clk(clk), .MR(mr), .PE_n(c_pe_n), .U_D(c_u_d), .CEP_n(c_cep_n), .CET_n(c_cet_n), .P(c_p[3:0]),
`ifdef TTL_CNT_MODULO_EN
    .M(4'hF),
`endif
    .Q(lo_q), .TC_n(lo_tc_n), .WRAP(lo_wrap)
  );
  ttl_updown_counter #(.DATA_WIDTH(4)) u_hi (
    .clk(clk), .MR(mr), .PE_n(c_pe_n), .U_D(c_u_d), .CEP_n(c_cep_n), .CET_n(lo_tc_n), .P(c_p[7:4]),
`ifdef TTL_CNT_MODULO_EN
    .M(4'hF),
`endif
    .Q(hi_q), .TC_n(hi_tc_n), .WRAP(hi_wrap)
  );
  function automatic int top_v();
`ifdef TTL_CNT_MODULO_EN
    return int'(m);
`else
    return 255;
`endif
  endfunction
  function automatic logic exp_tc();
    return !(!cet_n && (u_d ? mq >= top_v() : mq == 0));
  endfunction
  function automatic logic exp_ctc();
    return !(!c_cet_n && (c_u_d ? cm == 255 : cm == 0));
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    int t;
    @(posedge clk);
    t = top_v();
    if (!pe_n) begin
      mq = int'(p);
      mw = 0;
    end else if (!cep_n && !cet_n) begin
      mw = u_d ? mq >= t : mq == 0;
      mq = u_d ? (mw ? 0 : mq + 1) : (mw ? t : mq - 1);
    end else mw = 0;
    if (!c_pe_n) cm = int'(c_p);
    else if (!c_cep_n && !c_cet_n) cm = (c_u_d ? cm + 1 : cm + 255) % 256;
    #1;
    check("q", 32'(q), 32'(mq));
    check("wrap", 32'(wrap), 32'(mw));
    check("tc_n", 32'(tc_n), 32'(exp_tc()));
    check("casc_q", 32'({hi_q, lo_q}), 32'(cm));
    check("casc_tc_n", 32'(hi_tc_n), 32'(exp_ctc()));
  endtask
  initial begin
    #3;
    check("rst_q", 32'(q), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_tc_n", 32'(tc_n), 32'h1);
    @(negedge clk);
    mr = 1'b0;
    pe_n = 1'b0; p = 8'h5A;
    tick();
    pe_n = 1'b1; cep_n = 1'b0; cet_n = 1'b0; u_d = 1'b1;
`ifdef TTL_CNT_MODULO_EN
    m = 8'hC0;
`endif
    tick(); tick();
    #2 mr = 1'b1;
    #1;
    check("mr_async_q", 32'(q), 32'h0);
    check("mr_async_wrap", 32'(wrap), 32'h0);
    mq = 0; mw = 0; cm = 0;
    @(negedge clk) mr = 1'b0;
    repeat (3) tick();
    check("post_rst_q", 32'(q), 32'h3);
`ifdef TTL_CNT_MODULO_EN
    m = 8'd9;
    pe_n = 1'b0; p = 8'h0; tick();
    pe_n = 1'b1; u_d = 1'b0; tick();
    check("mod_down_wrap_q", 32'(q), 32'h9);
    check("mod_down_wrap_w", 32'(wrap), 32'h1);
    tick();
    check("mod_down_q", 32'(q), 32'h8);
    pe_n = 1'b0; p = 8'd9; u_d = 1'b1; tick();
    pe_n = 1'b1; tick();
    check("mod_up_wrap_q", 32'(q), 32'h0);
    pe_n = 1'b0; p = 8'd12; tick();
    pe_n = 1'b1; tick();
    check("mod_above_up_q", 32'(q), 32'h0);
    check("mod_above_up_w", 32'(wrap), 32'h1);
`else
    pe_n = 1'b0; p = 8'hFE; tick();
    pe_n = 1'b1; tick();
    check("bin_ff_q", 32'(q), 32'hFF);
    check("bin_ff_tc_n", 32'(tc_n), 32'h0);
    check("bin_ff_wrap", 32'(wrap), 32'h0);
    tick();
    check("bin_wrap_q", 32'(q), 32'h0);
    check("bin_wrap_w", 32'(wrap), 32'h1);
    tick();
    check("bin_after_w", 32'(wrap), 32'h0);
`endif
    pe_n = 1'b0; cep_n = 1'b0; cet_n = 1'b0; p = 8'h33; tick();
    check("prio_load_q", 32'(q), 32'h33);
    check("prio_load_w", 32'(wrap), 32'h0);
    pe_n = 1'b1; cep_n = 1'b1; u_d = 1'b0; tick();
    check("hold_q", 32'(q), 32'h33);
    u_d = 1'b1; #1;
    check("hold_tc_up", 32'(tc_n), 32'(exp_tc()));
    pe_n = 1'b0; p = 8'h0; tick();
    pe_n = 1'b1; u_d = 1'b0; tick();
    check("hold_tc_zero", 32'(tc_n), 32'h0);
`ifdef TTL_CNT_MODULO_EN
    m = 8'($urandom_range(0, 20));
`endif
    repeat (300) begin
      pe_n = ($urandom_range(0, 9) != 0);
      cep_n = ($urandom_range(0, 3) == 0);
      cet_n = ($urandom_range(0, 3) == 0);
      u_d = 1'($urandom);
`ifdef TTL_CNT_MODULO_EN
      p = 8'($urandom_range(0, 30));
`else
      p = 8'($urandom);
`endif
      tick();
    end
    pe_n = 1'b1; cep_n = 1'b1;
    c_pe_n = 1'b0; c_p = 8'h0F; c_cep_n = 1'b0; c_cet_n = 1'b0; c_u_d = 1'b1; tick();
    c_pe_n = 1'b1; tick();
    check("casc_up_carry", 32'({hi_q, lo_q}), 32'h10);
    c_pe_n = 1'b0; c_p = 8'hFF; tick();
    check("casc_tc_ff", 32'(hi_tc_n), 32'h0);
    c_p = 8'hFE; tick();
    check("casc_tc_fe", 32'(hi_tc_n), 32'h1);
    c_p = 8'h10; tick();
    c_pe_n = 1'b1; c_u_d = 1'b0; tick();
    check("casc_down_borrow", 32'({hi_q, lo_q}), 32'h0F);
    repeat (200) begin
      c_pe_n = ($urandom_range(0, 15) != 0);
      c_cep_n = ($urandom_range(0, 4) == 0);
      c_cet_n = ($urandom_range(0, 4) == 0);
      c_u_d = ($urandom_range(0, 7) != 0) ? c_u_d : ~c_u_d;
      c_p = 8'($urandom);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
